// File: rtl/lstm_seq_ctrl.sv
// Sequencing controller for one LSTM cell: loads weight/input/bias words for each
// gate group, kicks the MAC datapath, and streams h_t words at the end of a timestep.
module lstm_seq_ctrl #(
    parameter int N_W   = 32,
    parameter int N_B   = 32,
    parameter int N_OUT = 8,
    parameter int N_TS  = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_valid,
    input  logic        is_last_data_gate,
    input  logic        data_we,
    input  logic [31:0] data_in,
    input  logic        out_re,
    input  logic        mac_done,
    output logic        wt_we,
    output logic        x_we,
    output logic        b_we,
    output logic [31:0] wdata,
    output logic [4:0]  idx,
    output logic        mac_start,
    output logic        r_data,
    output logic        w_valid,
    output logic        t_valid,
    output logic [2:0]  out_idx,
    output logic [4:0]  ts_idx,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_X  = 3'd2,
        LOAD_B  = 3'd3,
        COMPUTE = 3'd4,
        OUTPUT  = 3'd5
    } state_t;

    localparam logic [4:0] W_LAST   = 5'(N_W - 1);
    localparam logic [4:0] B_LAST   = 5'(N_B - 1);
    localparam logic [2:0] OUT_LAST = 3'(N_OUT - 1);
    localparam logic [4:0] TS_LAST  = 5'(N_TS - 1);

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [2:0]  out_idx_reg;
    logic [4:0]  ts_idx_reg;
    logic        first_f_reg;
    logic        last_f_reg;
    logic        t_valid_reg;
    logic        err_reg;
    logic        mac_start_reg;

    // Write strobes are decoded straight from the state so the word lands in the same cycle.
    assign wt_we     = (state_reg == LOAD_W) && data_we;
    assign x_we      = (state_reg == LOAD_X) && data_we;
    assign b_we      = (state_reg == LOAD_B) && data_we;
    assign wdata     = data_in;
    assign idx       = cnt_reg;
    assign r_data    = (state_reg == IDLE);
    assign w_valid   = (state_reg == OUTPUT);
    assign mac_start = mac_start_reg;
    assign t_valid   = t_valid_reg;
    assign out_idx   = out_idx_reg;
    assign ts_idx    = ts_idx_reg;
    assign err       = err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 5'd0;
            out_idx_reg   <= 3'd0;
            ts_idx_reg    <= 5'd0;
            first_f_reg   <= 1'b1;
            last_f_reg    <= 1'b0;
            t_valid_reg   <= 1'b0;
            err_reg       <= 1'b0;
            mac_start_reg <= 1'b0;
        end else begin
            mac_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A word arriving here has no destination, even alongside r_valid.
                    if (data_we) begin
                        err_reg <= 1'b1;
                    end
                    if (r_valid) begin
                        state_reg   <= LOAD_W;
                        cnt_reg     <= 5'd0;
                        last_f_reg  <= is_last_data_gate;
                        t_valid_reg <= 1'b0;
                    end
                end
                LOAD_W: begin
                    if (data_we) begin
                        if (cnt_reg == W_LAST) begin
                            cnt_reg   <= 5'd0;
                            state_reg <= LOAD_X;
                        end else begin
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end
                end
                LOAD_X: begin
                    if (data_we) begin
                        if (first_f_reg) begin
                            state_reg <= LOAD_B;
                        end else begin
                            state_reg     <= COMPUTE;
                            mac_start_reg <= 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (data_we) begin
                        if (cnt_reg == B_LAST) begin
                            cnt_reg       <= 5'd0;
                            state_reg     <= COMPUTE;
                            first_f_reg   <= 1'b0;
                            mac_start_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end
                end
                COMPUTE: begin
                    if (data_we) begin
                        err_reg <= 1'b1;
                    end
                    if (mac_done) begin
                        state_reg <= last_f_reg ? OUTPUT : IDLE;
                    end
                end
                OUTPUT: begin
                    if (data_we) begin
                        err_reg <= 1'b1;
                    end
                    if (out_re) begin
                        if (out_idx_reg == OUT_LAST) begin
                            // Final h_t word closes the timestep; the next group reloads biases.
                            state_reg   <= IDLE;
                            t_valid_reg <= 1'b1;
                            first_f_reg <= 1'b1;
                            out_idx_reg <= 3'd0;
                            ts_idx_reg  <= (ts_idx_reg == TS_LAST) ? 5'd0 : ts_idx_reg + 5'd1;
                        end else begin
                            out_idx_reg <= out_idx_reg + 3'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl: group loads, output drain, timestep wrap,
// protocol errors and asynchronous reset in the middle of a bias load.
module tb_lstm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_valid, is_last_data_gate, data_we, out_re, mac_done;
    logic [31:0] data_in;
    logic        wt_we, x_we, b_we, mac_start, r_data, w_valid, t_valid, err;
    logic [31:0] wdata;
    logic [4:0]  idx, ts_idx;
    logic [2:0]  out_idx;

    int n_checks = 0;
    int n_err    = 0;

    lstm_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .r_valid(r_valid), .is_last_data_gate(is_last_data_gate),
        .data_we(data_we), .data_in(data_in),
        .out_re(out_re), .mac_done(mac_done),
        .wt_we(wt_we), .x_we(x_we), .b_we(b_we),
        .wdata(wdata), .idx(idx), .mac_start(mac_start),
        .r_data(r_data), .w_valid(w_valid), .t_valid(t_valid),
        .out_idx(out_idx), .ts_idx(ts_idx), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One data word; idx is only meaningful for weight and bias writes.
    task automatic word(input logic ew, input logic ex, input logic eb, input logic [4:0] eidx, input string tag);
        data_in = $urandom;
        data_we = 1'b1;
        #1;
        chk({tag, "_strobe"}, {61'd0, wt_we, x_we, b_we}, {61'd0, ew, ex, eb});
        chk({tag, "_wdata"}, {32'd0, wdata}, {32'd0, data_in});
        if (ew || eb) chk({tag, "_idx"}, {59'd0, idx}, {59'd0, eidx});
        @(posedge clk);
        #1;
        data_we = 1'b0;
    endtask

    task automatic start_group(input logic last);
        chk("start_rdata", {63'd0, r_data}, 64'd1);
        r_valid = 1'b1;
        is_last_data_gate = last;
        tick();
        r_valid = 1'b0;
        is_last_data_gate = 1'b0;
        chk("start_busy", {63'd0, r_data}, 64'd0);
    endtask

    task automatic load_body(input logic bias);
        for (int i = 0; i < 32; i++) word(1'b1, 1'b0, 1'b0, 5'(i), "wt");
        word(1'b0, 1'b1, 1'b0, 5'd0, "x");
        if (bias) for (int i = 0; i < 32; i++) word(1'b0, 1'b0, 1'b1, 5'(i), "b");
        chk("mac_start_hi", {63'd0, mac_start}, 64'd1);
        tick();
        chk("mac_start_lo", {63'd0, mac_start}, 64'd0);
        chk("compute_busy", {62'd0, r_data, w_valid}, 64'd0);
    endtask

    task automatic finish_group(input logic last);
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        chk("done_rdata", {63'd0, r_data}, {63'd0, !last});
        chk("done_wvalid", {63'd0, w_valid}, {63'd0, last});
    endtask

    task automatic drain(input logic [4:0] exp_ts);
        for (int k = 0; k < 8; k++) begin
            chk("out_wvalid", {63'd0, w_valid}, 64'd1);
            chk("out_idx", {61'd0, out_idx}, 64'(k));
            out_re = 1'b1;
            tick();
            out_re = 1'b0;
        end
        chk("ts_wvalid", {63'd0, w_valid}, 64'd0);
        chk("ts_tvalid", {63'd0, t_valid}, 64'd1);
        chk("ts_idx", {59'd0, ts_idx}, {59'd0, exp_ts});
        chk("ts_outidx", {61'd0, out_idx}, 64'd0);
        chk("ts_rdata", {63'd0, r_data}, 64'd1);
    endtask

    task automatic group(input logic last, input logic bias);
        $display("group: last=%0d bias=%0d ts=%0d", last, bias, ts_idx);
        start_group(last);
        load_body(bias);
        finish_group(last);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rdata"}, {63'd0, r_data}, 64'd1);
        chk({tag, "_flags"}, {59'd0, w_valid, t_valid, err, mac_start, 1'b0}, 64'd0);
        chk({tag, "_strobes"}, {61'd0, wt_we, x_we, b_we}, 64'd0);
        chk({tag, "_cnt"}, {51'd0, idx, out_idx, ts_idx}, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        r_valid = 1'b0; is_last_data_gate = 1'b0; data_we = 1'b0;
        data_in = 32'd0; out_re = 1'b0; mac_done = 1'b0;
        tick(); tick();
        data_we = 1'b1;
        #1;
        reset_checks("reset");
        data_we = 1'b0;
        rst = 1'b1;
        tick();

        // Timestep 0: bias group, plain group, last group with drain.
        group(1'b0, 1'b1);
        group(1'b0, 1'b0);
        group(1'b1, 1'b0);
        drain(5'd1);
        $display("timestep done: ts=%0d", ts_idx);

        // Stray out_re / mac_done in IDLE are ignored.
        out_re = 1'b1; tick(); out_re = 1'b0;
        mac_done = 1'b1; tick(); mac_done = 1'b0;
        chk("ignore_err", {63'd0, err}, 64'd0);
        chk("ignore_rdata", {63'd0, r_data}, 64'd1);
        chk("ignore_ts", {59'd0, ts_idx}, 64'd1);

        // Remaining 27 timesteps; ts_idx wraps back to 0.
        for (int t = 2; t <= 28; t++) begin
            group(1'b1, 1'b1);
            drain(5'(t % 28));
        end
        chk("wrap_ts", {59'd0, ts_idx}, 64'd0);
        chk("wrap_tvalid", {63'd0, t_valid}, 64'd1);

        // t_valid clears on the next group; data_we in COMPUTE is an error.
        $display("group: error in compute");
        start_group(1'b0);
        chk("tvalid_clr", {63'd0, t_valid}, 64'd0);
        load_body(1'b1);
        data_we = 1'b1;
        #1;
        chk("compute_drop", {61'd0, wt_we, x_we, b_we}, 64'd0);
        tick();
        data_we = 1'b0;
        chk("compute_err", {63'd0, err}, 64'd1);
        chk("compute_stay", {63'd0, r_data}, 64'd0);
        finish_group(1'b0);

        rst = 1'b0;
        #1;
        reset_checks("reset2");
        tick();
        rst = 1'b1;
        tick();

        // r_valid with data_we in IDLE: enter LOAD_W, drop the word, flag error.
        $display("group: r_valid with data_we");
        r_valid = 1'b1;
        data_we = 1'b1;
        #1;
        chk("idle_drop", {61'd0, wt_we, x_we, b_we}, 64'd0);
        tick();
        r_valid = 1'b0;
        data_we = 1'b0;
        chk("idle_err", {63'd0, err}, 64'd1);
        chk("idle_loadw", {63'd0, r_data}, 64'd0);
        for (int i = 0; i < 32; i++) word(1'b1, 1'b0, 1'b0, 5'(i), "wt2");
        word(1'b0, 1'b1, 1'b0, 5'd0, "x2");
        for (int i = 0; i < 10; i++) word(1'b0, 1'b0, 1'b1, 5'(i), "b2");

        // Asynchronous reset while the bias counter sits at 10.
        data_we = 1'b1;
        #1;
        chk("midb_idx", {58'd0, b_we, idx}, {58'd0, 1'b1, 5'd10});
        rst = 1'b0;
        #1;
        reset_checks("reset_midb");
        data_we = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        group(1'b0, 1'b1);
        chk("final_err", {63'd0, err}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
